// File: rtl/timed_cmd_issuer_if.sv
// Scheduler/counter/PHY bundle for timed_cmd_issuer.
// master drives commands and counter status; slave is the issuer.
interface timed_cmd_issuer_if #(
    parameter int nCK_PER_CLK = 4,
    parameter int CMD_W       = 24,
    parameter int DEPTH       = 4
);
    localparam int SW = $clog2(nCK_PER_CLK);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                         cmd_valid;
    logic [CMD_W-1:0]             cmd_data;
    logic                         cmd_ready;
    logic                         stall;
    logic                         tc_done;
    logic [SW-1:0]                tc_offset;
    logic                         tc_start;
    logic [SW-1:0]                tc_slot;
    logic [nCK_PER_CLK*CMD_W-1:0] phy_cmd;
    logic [nCK_PER_CLK-1:0]       phy_cmd_valid;
    logic [LW-1:0]                fifo_level;
    logic [15:0]                  issue_cnt;

    modport master (
        output cmd_valid, cmd_data, stall, tc_done, tc_offset,
        input  cmd_ready, tc_start, tc_slot, phy_cmd,
        input  phy_cmd_valid, fifo_level, issue_cnt
    );

    modport slave (
        input  cmd_valid, cmd_data, stall, tc_done, tc_offset,
        output cmd_ready, tc_start, tc_slot, phy_cmd,
        output phy_cmd_valid, fifo_level, issue_cnt
    );
endinterface

// File: rtl/timed_cmd_issuer.sv
// Command FIFO that issues DDR commands into the PHY slot chosen
// by a timing-constraint counter and re-arms that counter.
module timed_cmd_issuer #(
    parameter int                 nCK_PER_CLK = 4,
    parameter int                 CMD_W       = 24,
    parameter int                 DEPTH       = 4,
    parameter logic [CMD_W-1:0]   IDLE_CMD    = 24'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    timed_cmd_issuer_if.slave     bus
);
    localparam int SW = $clog2(nCK_PER_CLK);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        WAIT,
        ISSUE
    } state_t;

    logic [CMD_W-1:0]             mem [DEPTH];
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [LW-1:0]                level;
    logic [nCK_PER_CLK*CMD_W-1:0] phy_cmd;
    logic [nCK_PER_CLK-1:0]       phy_vld;
    logic [15:0]                  cnt;
    logic                         ready;
    logic                         push;
    logic                         pop;
    state_t                       state;

    always_comb begin
        state = EMPTY;
        if (level != '0)
            state = (!bus.stall && bus.tc_done) ? ISSUE : WAIT;
    end

    // Reset masks both ends so nothing moves in the reset cycle.
    assign ready = rst || (level != LW'(DEPTH));
    assign push  = !rst && bus.cmd_valid && (level != LW'(DEPTH));
    assign pop   = !rst && (state == ISSUE);

    assign bus.cmd_ready     = ready;
    assign bus.tc_start      = pop;
    assign bus.tc_slot       = pop ? bus.tc_offset : '0;
    assign bus.phy_cmd       = phy_cmd;
    assign bus.phy_cmd_valid = phy_vld;
    assign bus.fifo_level    = level;
    assign bus.issue_cnt     = cnt;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.cmd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            cnt     <= '0;
            phy_vld <= '0;
            phy_cmd <= {nCK_PER_CLK{IDLE_CMD}};
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 16'd1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            for (int s = 0; s < nCK_PER_CLK; s++) begin
                if (pop && (bus.tc_offset == SW'(s))) begin
                    phy_cmd[s*CMD_W +: CMD_W] <= mem[rd_ptr];
                    phy_vld[s]                <= 1'b1;
                end else begin
                    phy_cmd[s*CMD_W +: CMD_W] <= IDLE_CMD;
                    phy_vld[s]                <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_timed_cmd_issuer.sv
// Directed scenarios plus random traffic for timed_cmd_issuer,
// checked every cycle against a queue-based reference.
module tb_timed_cmd_issuer;
    localparam int NCK   = 4;
    localparam int CW    = 24;
    localparam int DEPTH = 4;
    localparam logic [CW-1:0] IDLE = 24'h0;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    timed_cmd_issuer_if #(.nCK_PER_CLK(NCK), .CMD_W(CW), .DEPTH(DEPTH)) bus ();

    timed_cmd_issuer #(
        .nCK_PER_CLK(NCK), .CMD_W(CW), .DEPTH(DEPTH), .IDLE_CMD(IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    // Reference: a queue of commands plus the expected PHY image.
    logic [CW-1:0]     q[$];
    logic [NCK*CW-1:0] m_phy = {NCK{IDLE}};
    logic [NCK-1:0]    m_vld = '0;
    logic [15:0]       m_cnt = '0;
    bit                model_on = 0;

    always @(posedge clk) begin
        bit iss, psh;
        logic [CW-1:0] h;
        if (rst) begin
            q.delete();
            m_cnt    = '0;
            m_vld    = '0;
            m_phy    = {NCK{IDLE}};
            model_on = 1;
        end else begin
            iss = q.size() > 0 && !bus.stall && bus.tc_done;
            psh = bus.cmd_valid && q.size() < DEPTH;
            m_phy = {NCK{IDLE}};
            m_vld = '0;
            if (iss) begin
                h = q.pop_front();
                m_phy[int'(bus.tc_offset)*CW +: CW] = h;
                m_vld = NCK'(1) << bus.tc_offset;
                m_cnt = m_cnt + 16'd1;
            end
            if (psh)
                q.push_back(bus.cmd_data);
        end
    end

    always @(negedge clk) begin
        bit exp_iss;
        if (model_on) begin
            exp_iss = !rst && q.size() > 0 && !bus.stall && bus.tc_done;
            chk("ready", 128'(bus.cmd_ready), 128'(rst || q.size() < DEPTH));
            chk("level", 128'(bus.fifo_level), 128'(q.size()));
            chk("start", 128'(bus.tc_start), 128'(exp_iss));
            if (exp_iss)
                chk("slot", 128'(bus.tc_slot), 128'(bus.tc_offset));
            chk("vld", 128'(bus.phy_cmd_valid), 128'(m_vld));
            chk("phy", 128'(bus.phy_cmd), 128'(m_phy));
            chk("cnt", 128'(bus.issue_cnt), 128'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [CW-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = base + CW'(i);
            step();
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 24'h555555;
        bus.stall     = 1'b0;
        bus.tc_done   = 1'b0;
        bus.tc_offset = '0;

        // Reset held with a command offered
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 128'(bus.fifo_level), 128'(0));
        chk("rst_ready", 128'(bus.cmd_ready), 128'(1));
        chk("rst_vld", 128'(bus.phy_cmd_valid), 128'(0));
        chk("rst_phy", 128'(bus.phy_cmd), 128'({NCK{IDLE}}));
        chk("rst_start", 128'(bus.tc_start), 128'(0));
        chk("rst_cnt", 128'(bus.issue_cnt), 128'(0));
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        step();

        // Single command into slot 2
        bus.tc_done   = 1'b1;
        bus.tc_offset = 2'd2;
        push_n(1, 24'hABCDE);
        #1;
        chk("one_start", 128'(bus.tc_start), 128'(1));
        chk("one_slot", 128'(bus.tc_slot), 128'(2));
        step();
        chk("one_vld", 128'(bus.phy_cmd_valid), 128'(4'b0100));
        chk("one_data", 128'(bus.phy_cmd[2*CW +: CW]), 128'(24'hABCDE));
        chk("one_cnt", 128'(bus.issue_cnt), 128'(1));
        bus.tc_done = 1'b0;

        // Constraint wait then slot 3
        push_n(1, 24'h00C0DE);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wait_start", 128'(bus.tc_start), 128'(0));
            step();
        end
        bus.tc_done   = 1'b1;
        bus.tc_offset = 2'd3;
        #1;
        chk("wait_go", 128'(bus.tc_start), 128'(1));
        step();
        chk("wait_vld", 128'(bus.phy_cmd_valid), 128'(4'b1000));
        chk("wait_data", 128'(bus.phy_cmd[3*CW +: CW]), 128'(24'h00C0DE));
        bus.tc_done = 1'b0;

        // Fill past capacity, then drain in order
        push_n(5, 24'h000100);
        chk("full_level", 128'(bus.fifo_level), 128'(4));
        chk("full_ready", 128'(bus.cmd_ready), 128'(0));
        bus.tc_done   = 1'b1;
        bus.tc_offset = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_vld", 128'(bus.phy_cmd_valid), 128'(4'b0001));
            chk("drain_data", 128'(bus.phy_cmd[0 +: CW]),
                128'(24'h000100 + i));
        end
        bus.tc_done = 1'b0;
        step();
        chk("drain_level", 128'(bus.fifo_level), 128'(0));

        // Stall blocks issue while the counter is ready
        push_n(2, 24'h000200);
        bus.tc_done = 1'b1;
        bus.stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_start", 128'(bus.tc_start), 128'(0));
            step();
            chk("stall_level", 128'(bus.fifo_level), 128'(2));
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("unstall_start", 128'(bus.tc_start), 128'(1));
            step();
            chk("unstall_data", 128'(bus.phy_cmd[0 +: CW]),
                128'(24'h000200 + i));
        end
        chk("unstall_level", 128'(bus.fifo_level), 128'(0));
        bus.tc_done = 1'b0;

        // Reset landing on an issue cycle
        push_n(3, 24'h000300);
        bus.tc_done = 1'b1;
        rst         = 1'b1;
        step();
        chk("mrst_vld", 128'(bus.phy_cmd_valid), 128'(0));
        chk("mrst_level", 128'(bus.fifo_level), 128'(0));
        chk("mrst_cnt", 128'(bus.issue_cnt), 128'(0));
        rst         = 1'b0;
        bus.tc_done = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_data  = CW'($urandom);
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.tc_done   = 1'($urandom_range(0, 1));
            bus.tc_offset = 2'($urandom_range(0, NCK - 1));
            rst           = ($urandom_range(0, 255) == 0);
            step();
        end
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
